// File: rtl/mem_if_pkg.sv
// Shared definitions for the main-memory line master: FSM states and
// line/beat geometry of the 4-cycle counted memory protocol.
package mem_if_pkg;

    localparam int unsigned LINE_WORDS     = 4;
    localparam int unsigned BEAT_CNT_W     = 2;
    localparam int unsigned ADD_WIDTH_DEF  = 10;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_BEAT,
        WR_BEAT,
        RD_CHECK,
        WR_CHECK,
        RESP
    } state_t;

endpackage

// File: rtl/mem_line_master.sv
// Initiator for word-wide main memory: moves one 4-word line per request
// using counted strobes, then checks the memory's sticky completion flag.
module mem_line_master
    import mem_if_pkg::*;
#(
    parameter int unsigned add_width  = ADD_WIDTH_DEF,
    parameter int unsigned data_width = DATA_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [add_width-1:0]             req_addr,
    input  logic [LINE_WORDS*data_width-1:0] req_wdata,
    output logic                             resp_valid,
    output logic [LINE_WORDS*data_width-1:0] resp_rdata,
    output logic                             resp_err,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [add_width-1:0]             add,
    output logic [data_width-1:0]            write_data,
    input  logic [LINE_WORDS*data_width-1:0] read_data,
    input  logic                             ready_to_read,
    input  logic                             finished_writing
);

    localparam int unsigned LINE_W = LINE_WORDS * data_width;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(LINE_WORDS - 1);

    state_t                  state, state_next;
    logic [BEAT_CNT_W-1:0]   beat, beat_next;
    logic [add_width-1:0]    base, base_next;
    logic [LINE_W-1:0]       line, line_next;

    logic                    mem_read_d, mem_write_d, resp_valid_d, resp_err_d;
    logic [add_width-1:0]    add_d;
    logic [data_width-1:0]   write_data_d;
    logic [LINE_W-1:0]       resp_rdata_d;

    assign req_ready = (state == IDLE);

    // State register with beat counter and latched request
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            base  <= '0;
            line  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            base  <= base_next;
            line  <= line_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        beat_next  = beat;
        base_next  = base;
        line_next  = line;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_write ? WR_BEAT : RD_BEAT;
                    beat_next  = '0;
                    // Low address bits are discarded; lines are always aligned
                    base_next  = {req_addr[add_width-1:2], req_addr[1:0] & 2'b00};
                    if (req_write)
                        line_next = req_wdata;
                end
            end
            RD_BEAT: begin
                beat_next = beat + 1'b1;
                if (beat == LAST_BEAT)
                    state_next = RD_CHECK;
            end
            WR_BEAT: begin
                beat_next = beat + 1'b1;
                if (beat == LAST_BEAT)
                    state_next = WR_CHECK;
            end
            RD_CHECK: state_next = RESP;
            WR_CHECK: state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output logic: memory-side values are derived from the next state so
    // they appear registered in the same cycle the FSM enters that state.
    always_comb begin
        mem_read_d   = (state_next == RD_BEAT);
        mem_write_d  = (state_next == WR_BEAT);
        resp_valid_d = (state_next == RESP);
        resp_err_d   = 1'b0;
        add_d        = add;
        write_data_d = write_data;
        resp_rdata_d = resp_rdata;

        if (state_next == RD_BEAT || state_next == RD_CHECK)
            add_d = base_next;
        if (state_next == WR_BEAT) begin
            add_d        = base_next + {{(add_width-BEAT_CNT_W){1'b0}}, beat_next};
            write_data_d = line_next[beat_next*data_width +: data_width];
        end

        // Flags are sticky from the previous transfer, so only trust them here
        if (state == RD_CHECK) begin
            resp_err_d = !ready_to_read;
            if (ready_to_read)
                resp_rdata_d = read_data;
        end
        if (state == WR_CHECK)
            resp_err_d = !finished_writing;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            add        <= '0;
            write_data <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            mem_read   <= mem_read_d;
            mem_write  <= mem_write_d;
            add        <= add_d;
            write_data <= write_data_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
        end
    end

endmodule

// File: doc/mem_line_master.md
Name: mem_line_master

Overview:
- Initiator-side controller for the word-wide main memory, sitting between the cache/fetch logic and main memory.
- Accepts one 4-word line request (refill or writeback) from upstream.
- Drives `mem_read` / `mem_write` / `add` / `write_data` with the memory's 4-cycle counted protocol.
- Checks the `ready_to_read` / `finished_writing` completion flags and returns the 128-bit line or a protocol-error indication.

Parameters:
- `add_width`, 10, word-address width driven on `add`.
- `data_width`, 32, memory word width; line width is 4*`data_width`.

Ports:
- `clk`  input  1  single clock, all state on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req_valid`  input  1  upstream request present.
- `req_ready`  output  1  high only in IDLE; request accepted on edge where valid&ready.
- `req_write`  input  1  1 = line writeback, 0 = line refill.
- `req_addr`  input  `add_width`  word address; bits [1:0] ignored, forced to 2'b00.
- `req_wdata`  input  4*`data_width`  writeback line; word i in bits [32i+31:32i].
- `resp_valid`  output  1  one-cycle pulse on completion.
- `resp_rdata`  output  4*`data_width`  refill line, valid with `resp_valid`; holds value until next refill.
- `resp_err`  output  1  valid with `resp_valid`; 1 = completion flag not seen.
- `mem_read`  output  1  to memory.
- `mem_write`  output  1  to memory.
- `add`  output  `add_width`  to memory.
- `write_data`  output  `data_width`  to memory.
- `read_data`  input  4*`data_width`  from memory; combinational on `add`.
- `ready_to_read`  input  1  from memory, registered flag.
- `finished_writing`  input  1  from memory, registered flag.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state = IDLE, beat counter = 0.
  - `mem_read`, `mem_write`, `resp_valid`, `resp_err` = 0.
  - `add`, `write_data`, `resp_rdata` = 0.
  - `req_ready` = 1.
- All memory-side outputs are registered. `req_ready` = (state == IDLE).
- States:
  - IDLE -> RD_BEAT or WR_BEAT on accept.
  - RD_BEAT (4 cycles) -> RD_CHECK.
  - WR_BEAT (4 cycles) -> WR_CHECK.
  - RD_CHECK / WR_CHECK (1 cycle) -> RESP.
  - RESP (1 cycle, `resp_valid` = 1) -> IDLE.
- On accept, latch base = {`req_addr`[`add_width`-1:2], 2'b00} and the write line.
- Read sequence:
  - `mem_read` = 1 for exactly 4 consecutive cycles; `add` = base throughout; `mem_write` = 0.
  - RD_CHECK: `mem_read` = 0, `add` still base.
  - Sample `ready_to_read`: if 1, capture `read_data` into `resp_rdata`, err = 0; if 0, err = 1 and `resp_rdata` is left unchanged.
- Write sequence:
  - `mem_write` = 1 for 4 cycles; beat i drives `add` = base+i, `write_data` = line word i (i = 0..3 in order).
  - WR_CHECK: `mem_write` = 0; sample `finished_writing`; err = !`finished_writing`.
- Completion flags are sampled ONLY in the CHECK state.
  - Memory flags are sticky and stale from the previous transfer, so they are never sampled during beats.
- Strobes are never held beyond 4 cycles (the memory counter advances on every strobe cycle).
- `mem_read` and `mem_write` are never both 1.
- Latency, with acceptance edge = cycle 0:
  - strobes in cycles 1-4, CHECK in cycle 5, `resp_valid` in cycle 6.
  - Next accept is possible at the end of cycle 7 (IDLE in cycle 7); throughput 1 line per 7 cycles.
- `req_valid` while busy: ignored (`req_ready` = 0); upstream holds the request.
- Reset mid-transfer: strobes drop at the reset edge and no `resp_valid` is issued.
  - The memory beat counter is then misaligned. The system reset must also realign memory; the next transfer reports `resp_err` if misaligned.
- `add` wraps naturally modulo 2^`add_width` (base+3 never crosses a line boundary).

Decomposition:
- Shared package `mem_if_pkg`:
  - state enum (IDLE, RD_BEAT, WR_BEAT, RD_CHECK, WR_CHECK, RESP).
  - `LINE_WORDS` = 4, `BEAT_CNT_W` = 2.
  - default `add_width` / `data_width`.
- Single module; no sub-module needed. Beat counter and state register stay inline.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0, `req_ready` = 1, no strobes.
- Write `req_addr`=0x045, line {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}:
  - `mem_write` high cycles 1-4 with `add` 0x044..0x047 and data 0xAAAA0000..0xDDDD0003.
  - `resp_valid` in cycle 6, `resp_err` = 0.
- Read back `req_addr`=0x046 -> `mem_read` high exactly cycles 1-4 at `add` 0x044; `resp_rdata` equals the written line, `resp_err` = 0, `resp_valid` in cycle 6.
- Back-to-back: `req_valid` held continuously with read then write -> second accepted in cycle 7; no strobe in cycles 5-7; stale `ready_to_read`=1 during write beats is ignored.
- Memory model forced to hold `ready_to_read` = 0 -> `resp_err` = 1 in cycle 6, `resp_rdata` unchanged.
- Reset asserted in cycle 2 of a write -> strobes 0 at the next edge, no `resp_valid`, state IDLE, `req_ready` = 1.
